// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic valid/ready pipeline register with optional two-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipe_stage_skid #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 138,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t state, state_n;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;
    logic m_valid, in_fire, out_fire, load_in, load_skid, load_s;
    always_ff @(posedge clk) begin
        if (!rst) state <= EMPTY;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (flush) state_n = EMPTY;
        else case (state)
            EMPTY:   state_n = in_fire ? ONE : EMPTY;
            ONE:     state_n = (out_fire && !in_fire) ? EMPTY : (load_skid ? TWO : ONE);
            TWO:     state_n = out_fire ? ONE : TWO;
            default: state_n = EMPTY;
        endcase
    end
    // With SKID the ready term depends only on the state flop; flush and reset just gate it.
    always_comb begin
        m_valid   = state != EMPTY;
        in_ready  = rst && !flush && ((SKID != 0) ? (state != TWO) : (!m_valid || out_ready));
        in_fire   = in_valid && in_ready;
        out_fire  = m_valid && out_ready;
        load_in   = in_fire && (state == EMPTY || out_fire);
        load_skid = (SKID != 0) && in_fire && state == ONE && !out_fire;
        load_s    = state == TWO && out_fire;
        out_valid = m_valid;
        out_ctrl  = m_ctrl;
        out_data  = m_data;
        occupancy = state;
    end
    // Vacated registers are zeroed so an invalid head always reads all-zero.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else begin
            if (load_in) {m_ctrl, m_data} <= {in_ctrl, in_data};
            else if (load_s) {m_ctrl, m_data} <= {s_ctrl, s_data};
            else if (out_fire) {m_ctrl, m_data} <= '0;
            if (load_skid) {s_ctrl, s_data} <= {in_ctrl, in_data};
            else if (load_s) {s_ctrl, s_data} <= '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) stall_cnt <= '0;
        else if (m_valid && !out_ready && !flush && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: random stimulus on a SKID=1/CNT_W=4 stage and a SKID=0 stage, checked
// against a queue model of the held entries and a saturating stall counter model.
module tb_pipe_stage_skid;
    localparam int CW = 5;
    localparam int DW = 32;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    logic flush [2], iv [2], ir [2], ov [2], ordy [2];
    logic [CW-1:0] ic [2], oc [2];
    logic [DW-1:0] id [2], od [2];
    logic [1:0] occ [2];
    logic [3:0] sc0;
    logic [15:0] sc1;
    int total = 0, bad = 0;
    logic [CW+DW-1:0] q [2][$];
    int cnt [2] = '{0, 0};
    int cmax [2] = '{15, 65535};
    typedef struct {int n; int pv; int pr; int pf; int prst;} ph_t;
    // cycles, %in_valid, %out_ready, %flush, %reset
    ph_t ph [8] = '{
        '{3,   100, 50,  0, 100},
        '{20,  100, 100, 0, 0},
        '{200, 70,  60,  0, 0},
        '{25,  100, 0,   0, 0},
        '{200, 70,  50,  8, 0},
        '{100, 50,  100, 0, 0},
        '{200, 60,  50,  5, 3},
        '{300, 60,  70,  3, 0}
    };
    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_ctrl(ic[0]), .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0]), .stall_cnt(sc0));
    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_ctrl(ic[1]), .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1]), .stall_cnt(sc1));
    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask
    // driver: random inputs, per-cycle state checks, push accepted entries
    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0; iv[k] = 1'b1; ordy[k] = 1'b0; ic[k] = '0; id[k] = '0;
        end
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < ph[p].n; c++) begin
                @(negedge clk);
                rst = ($urandom_range(99) < ph[p].prst) ? 1'b0 : 1'b1;
                for (int k = 0; k < 2; k++) begin
                    iv[k]    = $urandom_range(99) < ph[p].pv;
                    ordy[k]  = $urandom_range(99) < ph[p].pr;
                    flush[k] = $urandom_range(99) < ph[p].pf;
                    ic[k]    = CW'($urandom);
                    id[k]    = $urandom;
                end
                #2;
                for (int k = 0; k < 2; k++) begin
                    int n;
                    logic exp_ir;
                    n = q[k].size();
                    exp_ir = rst && !flush[k] && ((k == 0) ? (n < 2) : (n == 0 || ordy[k]));
                    chk("in_ready", k, 64'(ir[k]), 64'(exp_ir));
                    chk("out_valid", k, 64'(ov[k]), 64'(n > 0));
                    chk("occupancy", k, 64'(occ[k]), 64'(n));
                    chk("stall_cnt", k, (k == 0) ? 64'(sc0) : 64'(sc1), 64'(cnt[k]));
                    if (n == 0) chk("idle_head", k, 64'({oc[k], od[k]}), 64'(0));
                    if (!rst) cnt[k] = 0;
                    else if (n > 0 && !ordy[k] && !flush[k] && cnt[k] < cmax[k]) cnt[k]++;
                    if (iv[k] && ir[k]) q[k].push_back({ic[k], id[k]});
                end
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    // monitor: pop and compare each delivered entry, then apply flush/reset to the model
    always begin
        @(negedge clk);
        #3;
        for (int k = 0; k < 2; k++) begin
            if (!rst) q[k].delete();
            else begin
                if (ov[k] && ordy[k]) begin
                    if (q[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out dut%0d: got %0h expected nothing", k, {oc[k], od[k]});
                    end else chk("head", k, 64'({oc[k], od[k]}), 64'(q[k].pop_front()));
                end
                if (flush[k]) q[k].delete();
            end
        end
    end
endmodule
